// File: rtl/sd_crc_engine_if.sv
// Byte-stream and CRC result bundle between the SD command/data sequencer and the CRC engine.
// With SD_CRC_SERIAL_OUT_EN defined it also carries the serial CRC shift-out signals.
interface sd_crc_engine_if #(
   parameter int CRC_W = 16
);
   logic             in_valid;
   logic [7:0]       in_byte;
   logic             in_last;
   logic             in_ready;
   logic [CRC_W-1:0] crc;
   logic             crc_valid;
   logic             crc_ok;
`ifdef SD_CRC_SERIAL_OUT_EN
   logic             crc_shift;
   logic             crc_out_bit;
   logic             crc_out_done;

   modport master (
      output in_valid, in_byte, in_last, crc_shift,
      input  in_ready, crc, crc_valid, crc_ok, crc_out_bit, crc_out_done
   );
   modport slave (
      input  in_valid, in_byte, in_last, crc_shift,
      output in_ready, crc, crc_valid, crc_ok, crc_out_bit, crc_out_done
   );
`else
   modport master (
      output in_valid, in_byte, in_last,
      input  in_ready, crc, crc_valid, crc_ok
   );
   modport slave (
      input  in_valid, in_byte, in_last,
      output in_ready, crc, crc_valid, crc_ok
   );
`endif
endinterface

// File: rtl/sd_crc_engine.sv
// Byte-fed, bit-serial CRC generator/checker (CRC7 or CRC16-CCITT via parameters), falling-edge clocked.
// Optional serial CRC shift-out is enabled by defining SD_CRC_SERIAL_OUT_EN.
module sd_crc_engine #(
   parameter int               CRC_W = 16,
   parameter logic [CRC_W-1:0] POLY  = CRC_W'('h1021),
   parameter logic [CRC_W-1:0] INIT  = '0
) (
   input  logic            spi_clk,
   input  logic            reset,
   input  logic            clear,
   input  logic            en,
   sd_crc_engine_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_next;
   logic [2:0]       cnt;
   logic [7:0]       sh;
   logic             last_flag;
   logic [CRC_W-1:0] crc_q, crc_fold;
   logic             crc_valid_q, crc_ok_q;
   logic             ready, accept, byte_end;

   function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
      return {c[CRC_W-2:0], 1'b0} ^ (POLY & {CRC_W{c[CRC_W-1] ^ b}});
   endfunction

   assign crc_fold = crc_step(crc_q, sh[7]);
   assign byte_end = (state == SHIFT) && (cnt == 3'd0);
   // The final bit edge of a last byte finishes the frame, so no new byte is taken there.
   assign ready    = !reset && en && !clear &&
                     (state == IDLE || state == DONE || (byte_end && !last_flag));
   assign accept   = ready && bus.in_valid;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = SHIFT;
         SHIFT:   if (cnt == 3'd0) begin
                     if (last_flag)   state_next = DONE;
                     else if (accept) state_next = SHIFT;
                     else             state_next = IDLE;
                  end
         DONE:    if (accept) state_next = SHIFT;
         default: state_next = IDLE;
      endcase
      if (clear) state_next = IDLE;
   end

   always_ff @(negedge spi_clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= 3'd0;
         sh          <= 8'd0;
         last_flag   <= 1'b0;
         crc_q       <= INIT;
         crc_valid_q <= 1'b0;
         crc_ok_q    <= 1'b0;
      end else if (en) begin
         state <= state_next;
         if (clear) begin
            cnt         <= 3'd0;
            last_flag   <= 1'b0;
            crc_q       <= INIT;
            crc_valid_q <= 1'b0;
            crc_ok_q    <= 1'b0;
         end else begin
            if (state == SHIFT) begin
               crc_q <= crc_fold;
               sh    <= {sh[6:0], 1'b0};
               cnt   <= cnt - 3'd1;
            end
            if (byte_end && last_flag) begin
               crc_valid_q <= 1'b1;
               crc_ok_q    <= (crc_fold == '0);
            end
            if (accept) begin
               sh        <= bus.in_byte;
               last_flag <= bus.in_last;
               cnt       <= 3'd7;
               // A byte taken in DONE opens a fresh frame.
               if (state == DONE) begin
                  crc_q       <= INIT;
                  crc_valid_q <= 1'b0;
                  crc_ok_q    <= 1'b0;
               end
            end
         end
      end
   end

   assign bus.in_ready  = ready;
   assign bus.crc       = crc_q;
   assign bus.crc_valid = crc_valid_q;
   assign bus.crc_ok    = crc_ok_q;

`ifdef SD_CRC_SERIAL_OUT_EN
   localparam int SC_W = $clog2(CRC_W + 1);

   logic [CRC_W-1:0] shadow;
   logic [SC_W-1:0]  shift_cnt;
   logic             out_done;

   always_ff @(negedge spi_clk or posedge reset) begin
      if (reset) begin
         shadow    <= '0;
         shift_cnt <= '0;
         out_done  <= 1'b0;
      end else if (en) begin
         if (clear || (accept && state == DONE)) begin
            shadow    <= '0;
            shift_cnt <= '0;
            out_done  <= 1'b0;
         end else if (byte_end && last_flag) begin
            shadow    <= crc_fold;
            shift_cnt <= '0;
            out_done  <= 1'b0;
         end else if (state == DONE && bus.crc_shift && !out_done) begin
            shadow    <= {shadow[CRC_W-2:0], 1'b0};
            shift_cnt <= shift_cnt + SC_W'(1);
            if (shift_cnt == SC_W'(CRC_W - 1)) out_done <= 1'b1;
         end
      end
   end

   assign bus.crc_out_bit  = shadow[CRC_W-1];
   assign bus.crc_out_done = out_done;
`endif
endmodule

// File: tb/tb_sd_crc_engine.sv
// Scoreboard bench for sd_crc_engine: CRC16 and CRC7 instances driven with directed byte streams.
module tb_sd_crc_engine;
   typedef struct {
      logic [15:0] crc;
      logic        ok;
   } exp_t;

   logic clk = 1'b0;
   logic reset, clear, en;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   last_acc = 0;
   exp_t q16[$];
   exp_t q7[$];
   exp_t m16, m7;
   logic pv16 = 1'b0;
   logic pv7 = 1'b0;

   always #5 clk = ~clk;

   sd_crc_engine_if #(.CRC_W(16)) if16 ();
   sd_crc_engine_if #(.CRC_W(7))  if7 ();

   sd_crc_engine #(.CRC_W(16), .POLY(16'h1021), .INIT(16'h0000)) u16 (
      .spi_clk(clk), .reset(reset), .clear(clear), .en(en), .bus(if16)
   );
   sd_crc_engine #(.CRC_W(7), .POLY(7'h09), .INIT(7'h00)) u7 (
      .spi_clk(clk), .reset(reset), .clear(clear), .en(en), .bus(if7)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   initial forever begin
      @(negedge clk);
      cyc++;
   end

   // Monitor: pop and compare on each rising crc_valid.
   initial forever begin
      @(posedge clk);
      if (if16.crc_valid && !pv16) begin
         if (q16.size() == 0) chk("unexpected_valid16", 1, 0);
         else begin
            m16 = q16.pop_front();
            chk("crc16", 32'(if16.crc), 32'(m16.crc));
            chk("crc_ok16", 32'(if16.crc_ok), 32'(m16.ok));
            chk("latency16", cyc - last_acc, 8);
         end
      end
      if (if7.crc_valid && !pv7) begin
         if (q7.size() == 0) chk("unexpected_valid7", 1, 0);
         else begin
            m7 = q7.pop_front();
            chk("crc7", 32'(if7.crc), 32'(m7.crc));
            chk("crc_ok7", 32'(if7.crc_ok), 32'(m7.ok));
            chk("latency7", cyc - last_acc, 8);
         end
      end
      pv16 = if16.crc_valid;
      pv7  = if7.crc_valid;
   end

   task automatic send(input int which, input logic [7:0] b, input logic last);
      bit got = 1'b0;
      if (which == 0) begin
         if16.in_valid = 1'b1; if16.in_byte = b; if16.in_last = last;
      end else begin
         if7.in_valid = 1'b1; if7.in_byte = b; if7.in_last = last;
      end
      for (int i = 0; i < 200 && !got; i++) begin
         #1;
         if ((which == 0 && if16.in_ready) || (which != 0 && if7.in_ready)) begin
            got = 1'b1;
            last_acc = cyc + 1;
         end
         @(posedge clk);
      end
      if (!got) chk("accept_timeout", 0, 1);
   endtask

   task automatic idle();
      if16.in_valid = 1'b0;
      if7.in_valid  = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && (q16.size() != 0 || q7.size() != 0); i++) begin
         @(posedge clk);
         #2;
      end
      chk("drain_pending", q16.size() + q7.size(), 0);
   endtask

   task automatic stream_123(input bit cadence);
      logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      int prev = 0;
      q16.push_back('{crc: 16'h31C3, ok: 1'b0});
      for (int k = 0; k < 9; k++) begin
         send(0, msg[k], k == 8);
         if (cadence && k > 0) chk("cadence", last_acc - prev, 8);
         prev = last_acc;
      end
      idle();
   endtask

   task automatic ff_block(input int n);
      for (int k = 0; k < n; k++) send(0, 8'hFF, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; clear = 1'b0; en = 1'b1;
      if16.in_valid = 1'b0; if16.in_byte = 8'h00; if16.in_last = 1'b0;
      if7.in_valid  = 1'b0; if7.in_byte  = 8'h00; if7.in_last  = 1'b0;
`ifdef SD_CRC_SERIAL_OUT_EN
      if16.crc_shift = 1'b0;
      if7.crc_shift  = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(if16.in_ready), 0);
      chk("rst_crc16", 32'(if16.crc), 0);
      chk("rst_valid", 32'(if16.crc_valid), 0);
      chk("rst_ok", 32'(if16.crc_ok), 0);
      chk("rst_crc7", 32'(if7.crc), 0);
      @(posedge clk);
      reset = 1'b0;
      #1;
      chk("idle_ready", 32'(if16.in_ready), 1);

      // CRC7 CMD0, then CMD8 started from DONE
      q7.push_back('{crc: 16'h004A, ok: 1'b0});
      send(1, 8'h40, 0); send(1, 8'h00, 0); send(1, 8'h00, 0); send(1, 8'h00, 0);
      send(1, 8'h00, 1);
      idle();
      drain();
      repeat (3) @(posedge clk);
      #1;
      chk("hold_valid7", 32'(if7.crc_valid), 1);
      chk("hold_crc7", 32'(if7.crc), 32'h4A);
      q7.push_back('{crc: 16'h0043, ok: 1'b0});
      send(1, 8'h48, 0); send(1, 8'h00, 0); send(1, 8'h00, 0); send(1, 8'h01, 0);
      send(1, 8'hAA, 1);
      idle();
      drain();

      // CRC16 "123456789" back-to-back
      stream_123(1'b1);
      drain();
      repeat (3) @(posedge clk);
      #1;
      chk("hold_crc16", 32'(if16.crc), 32'h31C3);
      chk("hold_valid16", 32'(if16.crc_valid), 1);

`ifdef SD_CRC_SERIAL_OUT_EN
      begin
         logic [15:0] sbits = 16'h31C3;
         @(posedge clk);
         if16.crc_shift = 1'b1;
         for (int i = 0; i < 16; i++) begin
            #1;
            chk("serial_bit", 32'(if16.crc_out_bit), 32'(sbits[15-i]));
            if (i == 0) chk("serial_done_early", 32'(if16.crc_out_done), 0);
            @(posedge clk);
         end
         #1;
         chk("serial_done", 32'(if16.crc_out_done), 1);
         repeat (2) @(posedge clk);
         #1;
         chk("serial_done_hold", 32'(if16.crc_out_done), 1);
         chk("serial_crc_hold", 32'(if16.crc), 32'h31C3);
         if16.crc_shift = 1'b0;
      end
`endif

      // 512 x FF, then residue checks
      q16.push_back('{crc: 16'h7FA1, ok: 1'b0});
      ff_block(511);
      send(0, 8'hFF, 1);
      idle();
      drain();
      q16.push_back('{crc: 16'h0000, ok: 1'b1});
      ff_block(512);
      send(0, 8'h7F, 0);
      send(0, 8'hA1, 1);
      idle();
      drain();
      q16.push_back('{crc: 16'h1021, ok: 1'b0});
      ff_block(512);
      send(0, 8'h7F, 0);
      send(0, 8'hA0, 1);
      idle();
      drain();

      // clear in DONE together with in_valid
      @(posedge clk);
      clear = 1'b1;
      if16.in_valid = 1'b1; if16.in_byte = 8'h55; if16.in_last = 1'b1;
      #1;
      chk("clear_blocks_ready_done", 32'(if16.in_ready), 0);
      @(posedge clk);
      clear = 1'b0;
      idle();
      #1;
      chk("clear_valid", 32'(if16.crc_valid), 0);
      chk("clear_crc_done", 32'(if16.crc), 0);

      // clear on the 3rd bit of a byte with in_valid high
      send(0, 8'h31, 0);
      send(0, 8'h32, 0);
      repeat (2) @(posedge clk);
      clear = 1'b1;
      #1;
      chk("clear_blocks_ready", 32'(if16.in_ready), 0);
      @(posedge clk);
      clear = 1'b0;
      idle();
      #1;
      chk("clear_crc_mid", 32'(if16.crc), 0);
      chk("clear_idle_ready", 32'(if16.in_ready), 1);
      stream_123(1'b0);
      drain();

      // en low for 5 clocks mid-byte
      fork
         stream_123(1'b0);
         begin
            repeat (20) @(posedge clk);
            en = 1'b0;
            #1;
            chk("en_low_ready", 32'(if16.in_ready), 0);
            repeat (5) @(posedge clk);
            en = 1'b1;
         end
      join
      drain();

      // asynchronous reset between edges
      @(posedge clk);
      if16.in_valid = 1'b1; if16.in_byte = 8'h12; if16.in_last = 1'b0;
      #3;
      reset = 1'b1;
      #1;
      chk("areset_crc", 32'(if16.crc), 0);
      chk("areset_valid", 32'(if16.crc_valid), 0);
      chk("areset_ok", 32'(if16.crc_ok), 0);
      chk("areset_ready", 32'(if16.in_ready), 0);
      @(posedge clk);
      reset = 1'b0;
      idle();
      #1;
      chk("post_reset_ready", 32'(if16.in_ready), 1);
      chk("post_reset_crc", 32'(if16.crc), 0);
      repeat (12) @(posedge clk);
      #1;
      chk("no_stray_valid", 32'(if16.crc_valid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
